// File: rtl/approx_add_pkg.sv
// approx_add_pkg
// Shared constants, the S1 operation record and the small helpers used by
// the approximate-adder arbiter and its interface.
//   ADD_W / LVL_W / WIDTH_W : adder, approx-level and width-field widths
//   s1_op_t                 : operation held in the adder-input register
//   width_to_mask(w)        : (2^(w+1))-1, i.e. w+1 low bits set
//   clamp_level(lvl, cap)   : min(lvl, cap)
package approx_add_pkg;

  localparam int ADD_W   = 32;
  localparam int LVL_W   = 3;
  localparam int WIDTH_W = 5;

  typedef struct packed {
    logic [ADD_W-1:0]   a;
    logic [ADD_W-1:0]   b;
    logic [ADD_W-1:0]   mask;
    logic [LVL_W-1:0]   level;
    logic               ci;
    logic [WIDTH_W-1:0] width;
  } s1_op_t;

  // A right shift of all-ones by (31 - w) leaves exactly w+1 low bits set,
  // so w=31 yields the full mask without needing a 33-bit intermediate.
  function automatic logic [ADD_W-1:0] width_to_mask(input logic [WIDTH_W-1:0] w);
    return {ADD_W{1'b1}} >> (WIDTH_W'(ADD_W - 1) - w);
  endfunction

  function automatic logic [LVL_W-1:0] clamp_level(input logic [LVL_W-1:0] lvl,
                                                   input logic [LVL_W-1:0] cap);
    return (lvl > cap) ? cap : lvl;
  endfunction

endpackage

// File: rtl/approx_add_arbiter_if.sv
// approx_add_arbiter_if
// Bundles the requester bus, the adder-side bus, the response channel, the
// level-cap CSR and the op counter of the arbiter.
//   slave  : the arbiter's view (consumes requests, drives the adder inputs,
//            produces responses)
//   master : the surrounding system's view (requesters, adder, consumer)
interface approx_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  import approx_add_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ADD_W-1:0]   req_a;
  logic [NUM_REQ*ADD_W-1:0]   req_b;
  logic [NUM_REQ-1:0]         req_ci;
  logic [NUM_REQ*LVL_W-1:0]   req_level;
  logic [NUM_REQ*WIDTH_W-1:0] req_width;
  logic [LVL_W-1:0]           cfg_level_cap;

  logic [ADD_W-1:0]           add_a;
  logic [ADD_W-1:0]           add_b;
  logic                       add_ci;
  logic [ADD_W-1:0]           add_size_enable;
  logic [LVL_W-1:0]           add_approx_level;
  logic [ADD_W-1:0]           add_s;
  logic                       add_co;

  logic                       resp_valid;
  logic                       resp_ready;
  logic [ID_W-1:0]            resp_id;
  logic [ADD_W-1:0]           resp_sum;
  logic                       resp_co;
  logic [31:0]                op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_ci, req_level, req_width, cfg_level_cap,
    output req_ready,
    output add_a, add_b, add_ci, add_size_enable, add_approx_level,
    input  add_s, add_co,
    output resp_valid, resp_id, resp_sum, resp_co, op_count,
    input  resp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_ci, req_level, req_width, cfg_level_cap,
    input  req_ready,
    input  add_a, add_b, add_ci, add_size_enable, add_approx_level,
    output add_s, add_co,
    input  resp_valid, resp_id, resp_sum, resp_co, op_count,
    output resp_ready
  );

endinterface

// File: rtl/approx_add_arbiter_rr.sv
// rr_arbiter
// Round-robin pointer plus one-hot grant. The grant is combinational from
// valid_i and is forced to zero while stall_i is high.
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid_i     : per-requester request
//   stall_i     : suppresses every grant and freezes the pointer
//   grant_o     : one-hot grant (zero when nothing is granted)
//   grantId_o   : index of the granted requester
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   valid_i,
  input  logic           stall_i,
  output logic [N-1:0]   grant_o,
  output logic [IDW-1:0] grantId_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] cand;
  logic           found;

  // Scan circularly from the pointer; the first valid requester wins.
  always_comb begin
    grant_o   = '0;
    grantId_o = '0;
    found     = 1'b0;
    cand      = '0;
    if (!stall_i) begin
      for (int k = 0; k < N; k++) begin
        cand = IDW'((int'(ptr_q) + k) % N);
        if (!found && valid_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          grantId_o     = cand;
        end
      end
    end
  end

  // A grant is always an accept, so the winner's successor becomes the new
  // highest priority; the explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grantId_o == IDW'(N - 1)) ? '0 : grantId_o + IDW'(1);
    end
  end

  // Pointer register; reset gives requester 0 the highest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter
// Shares one approximate adder between NUM_REQ requesters: round-robin
// arbitration, an adder-input register (S1) and a response register (S2)
// with valid/ready backpressure, plus a count of completed responses.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester bus, adder bus, response channel, level cap CSR
//                and op_count (see approx_add_arbiter_if)
module approx_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_add_arbiter_if.slave  bus
);
  import approx_add_pkg::*;

  logic               s2Stall;
  logic               s1Stall;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantId;
  logic [WIDTH_W-1:0] selWidth;
  logic [ADD_W-1:0]   selMask;
  s1_op_t             selOp;

  s1_op_t             s1Op_q, s1Op_d;
  logic [ID_W-1:0]    s1Id_q, s1Id_d;
  logic               s1Valid_q, s1Valid_d;
  logic [ADD_W-1:0]   respSum_q, respSum_d;
  logic               respCo_q, respCo_d;
  logic [ID_W-1:0]    respId_q, respId_d;
  logic               respValid_q, respValid_d;
  logic [31:0]        opCount_q, opCount_d;

  assign s2Stall = respValid_q & ~bus.resp_ready;
  assign s1Stall = s1Valid_q & s2Stall;
  assign accept  = |grant;

  rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (bus.req_valid),
    .stall_i   (s1Stall),
    .grant_o   (grant),
    .grantId_o (grantId)
  );

  assign selWidth = bus.req_width[int'(grantId)*WIDTH_W +: WIDTH_W];
  assign selMask  = width_to_mask(selWidth);

  // Pick the granted requester's operation; operand bits above the active
  // width are zeroed so the adder never sees stale upper bits.
  always_comb begin
    selOp.a     = bus.req_a[int'(grantId)*ADD_W +: ADD_W] & selMask;
    selOp.b     = bus.req_b[int'(grantId)*ADD_W +: ADD_W] & selMask;
    selOp.mask  = selMask;
    selOp.level = clamp_level(bus.req_level[int'(grantId)*LVL_W +: LVL_W], bus.cfg_level_cap);
    selOp.ci    = bus.req_ci[grantId];
    selOp.width = selWidth;
  end

  // S1: load on accept, hold under stall, otherwise just drop s1Valid and
  // leave the adder inputs as they were.
  always_comb begin
    s1Op_d    = s1Op_q;
    s1Id_d    = s1Id_q;
    s1Valid_d = s1Valid_q;
    if (!s1Stall) begin
      s1Valid_d = accept;
      if (accept) begin
        s1Op_d = selOp;
        s1Id_d = grantId;
      end
    end
  end

  // S2: capture the adder result whenever it can move forward. Only full
  // 32-bit operations report a carry. A consumed response with nothing
  // behind it empties the register.
  always_comb begin
    respSum_d   = respSum_q;
    respCo_d    = respCo_q;
    respId_d    = respId_q;
    respValid_d = respValid_q;
    if (s1Valid_q && !s2Stall) begin
      respValid_d = 1'b1;
      respSum_d   = bus.add_s;
      respCo_d    = (s1Op_q.width == WIDTH_W'(ADD_W - 1)) & bus.add_co;
      respId_d    = s1Id_q;
    end else if (!s1Valid_q && bus.resp_ready) begin
      respValid_d = 1'b0;
    end
    opCount_d = opCount_q + 32'(respValid_q & bus.resp_ready);
  end

  // Pipeline registers; reset drops any in-flight operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Op_q      <= '0;
      s1Id_q      <= '0;
      s1Valid_q   <= 1'b0;
      respSum_q   <= '0;
      respCo_q    <= 1'b0;
      respId_q    <= '0;
      respValid_q <= 1'b0;
      opCount_q   <= '0;
    end else begin
      s1Op_q      <= s1Op_d;
      s1Id_q      <= s1Id_d;
      s1Valid_q   <= s1Valid_d;
      respSum_q   <= respSum_d;
      respCo_q    <= respCo_d;
      respId_q    <= respId_d;
      respValid_q <= respValid_d;
      opCount_q   <= opCount_d;
    end
  end

  assign bus.req_ready        = grant;
  assign bus.add_a            = s1Op_q.a;
  assign bus.add_b            = s1Op_q.b;
  assign bus.add_ci           = s1Op_q.ci;
  assign bus.add_size_enable  = s1Op_q.mask;
  assign bus.add_approx_level = s1Op_q.level;
  assign bus.resp_valid       = respValid_q;
  assign bus.resp_sum         = respSum_q;
  assign bus.resp_co          = respCo_q;
  assign bus.resp_id          = respId_q;
  assign bus.op_count         = opCount_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb_approx_add_arbiter
// Self-checking bench for approx_add_arbiter: a table of single operations,
// then hand-written reset, fairness and backpressure sequences. Responses
// are checked against a scoreboard queue filled when stimulus is driven.
module tb_approx_add_arbiter;
  import approx_add_pkg::*;

  localparam int NR  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  approx_add_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus ();

  approx_add_arbiter #(.NUM_REQ(NR), .ID_W(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Exact stand-in for the approximate adder, limited to size_enable.
  logic [ADD_W:0] rawSum;
  assign rawSum      = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{ADD_W{1'b0}}, bus.add_ci};
  assign bus.add_s   = rawSum[ADD_W-1:0] & bus.add_size_enable;
  assign bus.add_co  = rawSum[ADD_W];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [2:0]  lvl;
    logic [4:0]  w;
    logic [2:0]  cap;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expMask;
    logic [2:0]  expLvl;
    logic [31:0] expSum;
    logic        expCo;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        co;
  } resp_t;

  resp_t       sbQ[$];
  resp_t       monExp;
  vec_t        vecs[7];
  int          nChecks       = 0;
  int          nFails        = 0;
  int          expOpCount    = 0;
  int          totalAccepted = 0;

  logic [31:0] fa[NR]     = '{32'h0101_0101, 32'hFFFF_0000, 32'h00FF_FF00, 32'h8000_0001};
  logic [31:0] fb[NR]     = '{32'h00F0_0F00, 32'h0001_0000, 32'h0000_0100, 32'h8000_0000};
  logic [4:0]  fw[NR]     = '{5'd7, 5'd15, 5'd23, 5'd31};
  logic [3:0]  fciMask    = 4'b1010;
  int          bpGrant[8] = '{0, 1, -1, -1, -1, 2, 3, 0};
  logic [7:0]  bpReady    = 8'b1110_0011;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
    end
  endtask

  // Reference result computed bit by bit from the raw request fields.
  function automatic resp_t modelOp(input int id, input logic [31:0] a, input logic [31:0] b,
                                    input logic ci, input logic [4:0] w);
    logic [31:0] m;
    logic [32:0] s;
    resp_t       r;
    m = '0;
    for (int i = 0; i <= int'(w); i++) m[i] = 1'b1;
    s = {1'b0, a & m} + {1'b0, b & m} + {32'd0, ci};
    r.id  = id;
    r.sum = s[31:0] & m;
    r.co  = (w == 5'd31) ? s[32] : 1'b0;
    return r;
  endfunction

  task automatic setSlot(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [2:0] lvl, input logic [4:0] w);
    bus.req_a[id*32 +: 32]    = a;
    bus.req_b[id*32 +: 32]    = b;
    bus.req_ci[id]            = ci;
    bus.req_level[id*3 +: 3]  = lvl;
    bus.req_width[id*5 +: 5]  = w;
  endtask

  // Only the vector's requester is valid; every other slot carries junk so
  // a wrong operand select shows up.
  task automatic applyStimulus(input vec_t v);
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      setSlot(i, $urandom, $urandom, 1'($urandom), 3'($urandom), 5'($urandom));
    end
    setSlot(v.id, v.a, v.b, v.ci, v.lvl, v.w);
    bus.cfg_level_cap      = v.cap;
    bus.req_valid[v.id]    = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_drain_left"}, 32'(sbQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Response monitor: sampled on the falling edge, so a valid&ready seen
  // here is the transfer that happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("op_count", bus.op_count, 32'(expOpCount));
      if (bus.resp_valid && bus.resp_ready) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected_resp: got id %0d sum 0x%08h, required no response",
                   bus.resp_id, bus.resp_sum);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("resp_id", 32'(bus.resp_id), 32'(monExp.id));
          checkOutput("resp_sum", bus.resp_sum, monExp.sum);
          checkOutput("resp_co", 32'(bus.resp_co), 32'(monExp.co));
          expOpCount++;
        end
      end
    end
  end

  initial begin
    rst_n             = 1'b0;
    bus.req_valid     = '0;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.req_ci        = '0;
    bus.req_level     = '0;
    bus.req_width     = '0;
    bus.cfg_level_cap = 3'd7;
    bus.resp_ready    = 1'b1;

    //            id  a             b             ci    lvl   w      cap   expA          expB          expMask       expLvl expSum        expCo
    vecs[0] = '{1, 32'h0000FFFF, 32'h00000001, 1'b0, 3'd0, 5'd31, 3'd7, 32'h0000FFFF, 32'h00000001, 32'hFFFFFFFF, 3'd0, 32'h00010000, 1'b0};
    vecs[1] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd3, 5'd7,  3'd7, 32'h000000FF, 32'h00000001, 32'h000000FF, 3'd3, 32'h00000000, 1'b0};
    vecs[2] = '{2, 32'h12345678, 32'h11111111, 1'b1, 3'd6, 5'd31, 3'd2, 32'h12345678, 32'h11111111, 32'hFFFFFFFF, 3'd2, 32'h2345678A, 1'b0};
    vecs[3] = '{3, 32'h00000005, 32'h00000003, 1'b0, 3'd6, 5'd31, 3'd7, 32'h00000005, 32'h00000003, 32'hFFFFFFFF, 3'd6, 32'h00000008, 1'b0};
    vecs[4] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3'd1, 5'd31, 3'd7, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 3'd1, 32'h00000000, 1'b1};
    vecs[5] = '{2, 32'hABCD1234, 32'h0000FFFF, 1'b0, 3'd7, 5'd15, 3'd5, 32'h00001234, 32'h0000FFFF, 32'h0000FFFF, 3'd5, 32'h00001233, 1'b0};
    vecs[6] = '{0, 32'h80000001, 32'h80000001, 1'b1, 3'd4, 5'd0,  3'd4, 32'h00000001, 32'h00000001, 32'h00000001, 3'd4, 32'h00000001, 1'b0};

    #1;
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_op_count", bus.op_count, 32'd0);
    checkOutput("rst_add_a", bus.add_a, 32'd0);
    checkOutput("rst_add_size_enable", bus.add_size_enable, 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table of single operations: grant, S1 contents, fixed latency.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_grant", i), 32'(bus.req_ready), 32'(1) << vecs[i].id);
      sbQ.push_back('{vecs[i].id, vecs[i].expSum, vecs[i].expCo});
      totalAccepted++;
      @(posedge clk);
      #1;
      bus.req_valid     = '0;
      bus.cfg_level_cap = 3'd0;
      #1;
      checkOutput($sformatf("v%0d_add_a", i), bus.add_a, vecs[i].expA);
      checkOutput($sformatf("v%0d_add_b", i), bus.add_b, vecs[i].expB);
      checkOutput($sformatf("v%0d_add_size_enable", i), bus.add_size_enable, vecs[i].expMask);
      checkOutput($sformatf("v%0d_add_approx_level", i), 32'(bus.add_approx_level), 32'(vecs[i].expLvl));
      checkOutput($sformatf("v%0d_add_ci", i), 32'(bus.add_ci), 32'(vecs[i].ci));
      checkOutput($sformatf("v%0d_resp_valid_t1", i), 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_resp_valid_t2", i), 32'(bus.resp_valid), 32'd1);
    end
    drain("vec");

    // Reset while S1 and S2 both hold operations from requester 2.
    setSlot(2, 32'h0000_1111, 32'h0000_2222, 1'b0, 3'd0, 5'd31);
    bus.req_valid = 4'b0100;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    checkOutput("pre_rst_resp_valid", 32'(bus.resp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    sbQ.delete();
    expOpCount    = 0;
    totalAccepted = 0;
    #1;
    checkOutput("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("async_rst_op_count", bus.op_count, 32'd0);
    checkOutput("async_rst_add_a", bus.add_a, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: everyone requests for 8 cycles, first grant must be 0.
    for (int i = 0; i < NR; i++) setSlot(i, fa[i], fb[i], fciMask[i], 3'(i), fw[i]);
    bus.cfg_level_cap = 3'd7;
    bus.resp_ready    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput($sformatf("fair_grant%0d", k), 32'(bus.req_ready), 32'(1) << (k % NR));
      if (k >= 2) checkOutput($sformatf("fair_resp_valid%0d", k), 32'(bus.resp_valid), 32'd1);
      sbQ.push_back(modelOp(k % NR, fa[k % NR], fb[k % NR], fciMask[k % NR], fw[k % NR]));
      totalAccepted++;
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    drain("fair");

    // Backpressure: resp_ready low for 3 cycles with the pipeline full.
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      bus.resp_ready = bpReady[k];
      #1;
      if (bpGrant[k] < 0) begin
        checkOutput($sformatf("bp_req_ready%0d", k), 32'(bus.req_ready), 32'd0);
        checkOutput($sformatf("bp_hold_sum%0d", k), bus.resp_sum, sbQ[0].sum);
        checkOutput($sformatf("bp_hold_id%0d", k), 32'(bus.resp_id), 32'(sbQ[0].id));
      end else begin
        checkOutput($sformatf("bp_grant%0d", k), 32'(bus.req_ready), 32'(1) << bpGrant[k]);
        sbQ.push_back(modelOp(bpGrant[k], fa[bpGrant[k]], fb[bpGrant[k]],
                              fciMask[bpGrant[k]], fw[bpGrant[k]]));
        totalAccepted++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    drain("bp");
    checkOutput("final_op_count", bus.op_count, 32'(totalAccepted));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/approx_add_arbiter.md
Name: approx_add_arbiter

Overview:
- Shares one 32-bit sizeable approximate Sklansky adder between NUM_REQ requesters, e.g. the ALU, address generation and the multiplier's final-add stage.
- Arbitrates round-robin and registers the adder inputs (operands, size_enable mask, approx_level).
- Captures the adder outputs into a response register with valid/ready backpressure.
- Applies a global approximation-level cap from a CSR.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester-id width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  one-hot grant/accept; the transfer happens when valid&ready
- req_a  in  NUM_REQ*32  operand A, packed with requester i at [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B, packed the same way
- req_ci  in  NUM_REQ  carry-in
- req_level  in  NUM_REQ*3  requested approx_level
- req_width  in  NUM_REQ*5  active width minus 1 (0 means 1 bit, 31 means 32 bits)
- cfg_level_cap  in  3  maximum approx_level permitted; requests above it are clamped
- add_a  out  32  adder operand A
- add_b  out  32  adder operand B
- add_ci  out  1  adder carry-in
- add_size_enable  out  32  adder size_enable
- add_approx_level  out  3  adder approx_level
- add_s  in  32  adder sum (combinational from add_* outputs)
- add_co  in  1  adder carry-out
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_id  out  ID_W  requester that owns the result
- resp_sum  out  32  sum
- resp_co  out  1  carry-out
- op_count  out  32  number of completed responses, wraps

Behaviour:
- Reset, asynchronous on rst_n low:
  - all add_* registers, resp_* registers, op_count and s1_valid clear to 0.
  - The round-robin pointer resets to 0 (requester 0 has highest priority).
- Pipeline:
  - Stage S1 is the adder-input register.
  - Stage S2 is the response register.
  - Latency is fixed: an accept in cycle T gives resp_valid in cycle T+2 when there is no backpressure.
  - Throughput is 1 op per cycle.
- Stall:
  - s2_stall = resp_valid & ~resp_ready.
  - s1_stall = s1_valid & s2_stall.
  - Under s1_stall, req_ready is all zero and S1/S2 hold their values.
- Grant:
  - When there is no s1_stall, the first valid requester at or after the pointer (circular) gets req_ready=1, combinationally from req_valid.
  - On accept, the pointer moves to the granted index + 1, modulo NUM_REQ.
  - No valid requests: no grant and the pointer is unchanged.
- S1 load on accept:
  - add_a and add_b take the operands with bits above req_width forced to 0.
  - add_size_enable = (2^(w+1))-1, where w = req_width; w=31 gives 0xFFFFFFFF.
  - add_approx_level = min(req_level, cfg_level_cap), with the cap sampled in the accept cycle.
  - add_ci = req_ci.
  - S1 also stores the id and width; s1_valid=1.
- No accept and no stall: s1_valid=0. add_* keep their old values; only s1_valid qualifies them.
- S2 load when s1_valid and not s2_stall:
  - resp_sum = add_s.
  - resp_co = add_co if the stored width = 31, else 0. Narrow operations do not report carry.
  - resp_id = stored id; resp_valid=1.
  - If !s1_valid and resp_ready, resp_valid falls to 0.
- op_count increments on each resp_valid & resp_ready, wrapping from 0xFFFFFFFF to 0.
- Simultaneous events: the response handshake and a new S2 load in the same cycle are allowed (full throughput).
- A cfg_level_cap change affects only operations accepted afterwards.
- Reset mid-operation drops in-flight S1/S2 operations with no response.

Decomposition:
- Shared package approx_add_pkg holds:
  - constants ADD_W=32, LVL_W=3, WIDTH_W=5;
  - function width_to_mask(w) returning a 32-bit mask;
  - function clamp_level(lvl, cap).
- One sub-module, rr_arbiter: a parameterised round-robin pointer plus one-hot grant with a stall input. The rest stays in the top module.

Test Plan:
- Single request, requester 1: a=0x0000FFFF, b=0x00000001, ci=0, level=0, width=31, cap=7.
  - Required: req_ready[1]=1, add_size_enable=0xFFFFFFFF.
  - Two cycles later: resp_sum=0x00010000, resp_co=0, resp_id=1, op_count goes to 1.
- Narrow op: a=0xFFFFFFFF, b=0x00000001, width=7.
  - Required: add_a=0x000000FF, add_size_enable=0x000000FF.
  - Response: resp_sum=0x00000000, resp_co=0.
- Clamp: level=6, cap=2 -> add_approx_level=2. Then cap=7, level=6 -> add_approx_level=6.
- Fairness: all 4 requesters valid continuously for 8 cycles, resp_ready=1.
  - Required grant order 0,1,2,3,0,1,2,3 and one response per cycle from cycle 2.
- Backpressure: hold resp_ready=0 for 3 cycles with requests pending.
  - Required: req_ready=0 and resp_sum/resp_id stable.
  - On release, ops resume with no loss or duplication; op_count matches the number of accepted ops.
- Reset with S1 and S2 full: assert rst_n=0 asynchronously.
  - Required: resp_valid=0 and op_count=0 immediately.
  - After release, the first grant goes to requester 0.
